uart_tx_ctrl: RTL



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_ctrl_if.sv | 36 +++
 rtl/uart_tx_serializer.sv | 52 +++++
 rtl/uart_tx_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit frame controller.
//   tx_state_t  : frame FSM states
//   PAR_EVEN/ODD: encodings of the PAR_TYP input
//   STOP_BITS   : stop cycles per frame (1, or 2 when UART_TX_TWO_STOP_EN
//                 is defined)
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_tx_ctrl_if
// Handshake and serial-line bundle between a TX data source and the UART
// transmit frame controller.
//   P_DATA     : parallel word to transmit            (source -> ctrl)
//   Data_Valid : P_DATA valid                          (source -> ctrl)
//   PAR_EN     : insert parity bit                     (source -> ctrl)
//   PAR_TYP    : 0 = even, 1 = odd parity              (source -> ctrl)
//   READY      : controller accepts a word this cycle  (ctrl -> source)
//   BUSY       : frame in progress                     (ctrl -> source)
//   TX_OUT     : serial line, idles high               (ctrl -> pad)
// Modports: master = data source side, slave = controller side.
// ----------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  READY;
    logic                  BUSY;
    logic                  TX_OUT;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  READY, BUSY, TX_OUT
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output READY, BUSY, TX_OUT
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
// Data shift register plus bit counter for one UART frame.
//   CLK     : bit-rate clock
//   RST     : synchronous active-high reset
//   i_load  : capture i_data and clear the bit counter
//   i_data  : parallel word
//   i_shift : shift right by one and advance the bit counter
//   o_bit   : current serial data bit (shift[0])
//   o_done  : counter is on the last data bit
// ----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    output logic                  o_bit,
    output logic                  o_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the shift register is ordinary flops, not a RAM, so it
            // can and does take a reset value like every other register.
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            // Hold on the last bit so the counter never wraps inside a frame.
            if (!o_done) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_bit  = r_shift[0];
    assign o_done = (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit frame controller, one CLK cycle per serial bit. Accepts one
// word per Data_Valid/READY handshake and sends start bit, data bits LSB
// first, optional parity bit and stop bit(s).
//   CLK : bit-rate clock
//   RST : synchronous active-high reset
//   bus : uart_tx_ctrl_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP in;
//         READY, BUSY, TX_OUT out)
// Build option: UART_TX_TWO_STOP_EN -> two stop cycles, READY only in the
// second one. Undefined -> one stop cycle.
// ----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);

    tx_state_t r_state;
    tx_state_t w_next;

    logic r_par_en;
    logic r_par_bit;

    logic w_ready;
    logic w_accept;
    logic w_last_stop;
    logic w_ser_bit;
    logic w_ser_done;
    logic w_tx;

`ifdef UART_TX_TWO_STOP_EN
    // Marks the second stop cycle; cleared whenever STOP is left.
    logic r_stop_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stop_cnt <= 1'b0;
        end else begin
            r_stop_cnt <= (r_state == STOP) && !r_stop_cnt;
        end
    end

    assign w_last_stop = r_stop_cnt;
`else
    assign w_last_stop = 1'b1;
`endif

    // A new word can be taken in the last stop cycle, so frames can run
    // back-to-back without an idle bit between them.
    assign w_ready  = (r_state == IDLE) || ((r_state == STOP) && w_last_stop);
    assign w_accept = bus.Data_Valid && w_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Parity options are frozen at acceptance; later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_par_en  <= bus.PAR_EN;
            r_par_bit <= (bus.PAR_TYP == PAR_EVEN) ? (^bus.P_DATA) : (~^bus.P_DATA);
        end
    end

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .CLK     (CLK),
        .RST     (RST),
        .i_load  (w_accept),
        .i_data  (bus.P_DATA),
        .i_shift (r_state == DATA),
        .o_bit   (w_ser_bit),
        .o_done  (w_ser_done)
    );

    always_comb begin
        // NOTE: default first, so every path assigns w_next and no latch
        // is inferred.
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = START;
                end
            end
            START: begin
                w_next = DATA;
            end
            DATA: begin
                if (w_ser_done) begin
                    w_next = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_next = STOP;
            end
            STOP: begin
                if (w_last_stop) begin
                    w_next = w_accept ? START : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Serial line decoded from registered state only; inputs never reach it.
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            START:   w_tx = 1'b0;
            DATA:    w_tx = w_ser_bit;
            PARITY:  w_tx = r_par_bit;
            default: w_tx = 1'b1;
        endcase
    end

    assign bus.READY  = w_ready;
    assign bus.BUSY   = (r_state != IDLE);
    assign bus.TX_OUT = w_tx;

endmodule
